// File: rtl/gng_ctrl_pkg.sv
// Shared types and constants for the GNG noise sequencer.
// Sigma is s<16,11>, so SIGMA_ONE represents unity gain.
package gng_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam int NB_FRAC   = 11;
  localparam int SIGMA_ONE = 1 << NB_FRAC;

endpackage

// File: rtl/gng_ctrl_fifo.sv
// Synchronous first-word-fall-through skid FIFO with occupancy count.
// A write and a pop in the same cycle are legal, including when full.
module gng_ctrl_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rd_ok;

  always_comb begin
    rd_ok  = i_rd && (cnt_q != '0);
    wptr_d = wptr_q + AW'(i_wr);
    rptr_d = rptr_q + AW'(rd_ok);
    cnt_d  = cnt_q + CW'(i_wr) - CW'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr) mem_q[wptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rptr_q];
  assign o_count = cnt_q;

  // The controller throttles ce so a write never lands on a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(i_wr && !rd_ok && (cnt_q == CW'(DEPTH))));

endmodule

// File: rtl/gng_noise_ctrl.sv
// Sequencer between gng_top and the channel adder: warm-up discard,
// burst gating of the GNG clock enable and between-burst sigma updates.
module gng_noise_ctrl
  import gng_ctrl_pkg::*;
#(
  parameter int NB_DATA        = 16,
  parameter int NB_COUNT       = 16,
  parameter int WARMUP_SAMPLES = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int SIGMA_RESET    = SIGMA_ONE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [NB_COUNT-1:0]   i_burst_len,
  input  logic [NB_DATA-1:0]    i_sigma,
  input  logic                  i_sigma_load,
  output logic                  o_gng_ce,
  output logic [NB_DATA-1:0]    o_sigma_multiplier,
  input  logic [2*NB_DATA-1:0]  i_gng_data,
  input  logic                  i_gng_valid,
  output logic [2*NB_DATA-1:0]  o_noise_data,
  output logic                  o_noise_valid,
  input  logic                  i_noise_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NB_COUNT-1:0] CMAX = '1;

  state_e              state_q, state_d;
  logic [NB_COUNT-1:0] warm_q, warm_d;
  logic [NB_COUNT-1:0] issued_q, issued_d;
  logic [NB_COUNT-1:0] recv_q, recv_d;
  logic [NB_COUNT-1:0] out_q, out_d;
  logic [NB_COUNT-1:0] len_q, len_d;
  logic [NB_DATA-1:0]  pend_q, pend_d;
  logic                pvld_q, pvld_d;
  logic [NB_DATA-1:0]  act_q, act_d;
  logic                en_q;
  logic                ce, wr, rd, done, room, more;
  logic [CW-1:0]       fifo_cnt;

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    len_d    = len_q;
    ce       = 1'b0;
    wr       = 1'b0;
    done     = 1'b0;
    rd       = (fifo_cnt != '0) && i_noise_ready;
    room     = ({{(NB_COUNT-CW){1'b0}}, fifo_cnt} + out_q)
               < NB_COUNT'(FIFO_DEPTH);
    more     = (len_q == '0) || (issued_q < len_q);

    unique case (state_q)
      ST_WARMUP: begin
        // Issue only as many enables as samples still to be discarded.
        ce = en_q && (warm_q > out_q);
        if (i_gng_valid && (warm_q != '0)) warm_d = warm_q - 1'b1;
        if ((warm_q == '0) && (out_q == '0)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_RUN;
          len_d    = i_burst_len;
          issued_d = '0;
          recv_d   = '0;
        end
      end
      ST_RUN: begin
        ce = room && more;
        wr = i_gng_valid;
        if (ce && (len_q != '0)) issued_d = issued_q + 1'b1;
        if (i_gng_valid && (recv_q != CMAX)) recv_d = recv_q + 1'b1;
        if (((len_q != '0) && (issued_q == len_q)) ||
            ((len_q == '0) && i_stop))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        wr = i_gng_valid;
        if (i_gng_valid && (recv_q != CMAX)) recv_d = recv_q + 1'b1;
        if ((out_q == '0) && (fifo_cnt == '0)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WARMUP;
    endcase

    unique case ({ce, i_gng_valid})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    pend_d = pend_q;
    pvld_d = pvld_q;
    act_d  = act_q;
    if (i_sigma_load) begin
      pend_d = i_sigma;
      pvld_d = 1'b1;
    end
    if (state_q == ST_IDLE) begin
      if (i_sigma_load) begin
        act_d  = i_sigma;
        pvld_d = 1'b0;
      end else if (pvld_q) begin
        act_d  = pend_q;
        pvld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_WARMUP;
      warm_q   <= NB_COUNT'(WARMUP_SAMPLES);
      issued_q <= '0;
      recv_q   <= '0;
      out_q    <= '0;
      len_q    <= '0;
      pend_q   <= '0;
      pvld_q   <= 1'b0;
      act_q    <= NB_DATA'(SIGMA_RESET);
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      out_q    <= out_d;
      len_q    <= len_d;
      pend_q   <= pend_d;
      pvld_q   <= pvld_d;
      act_q    <= act_d;
      en_q     <= 1'b1;
    end
  end

  gng_ctrl_fifo #(
    .WIDTH (2*NB_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .i_wr    (wr),
    .i_wdata (i_gng_data),
    .i_rd    (rd),
    .o_rdata (o_noise_data),
    .o_count (fifo_cnt)
  );

  assign o_gng_ce           = ce;
  assign o_sigma_multiplier = act_q;
  assign o_noise_valid      = (fifo_cnt != '0);
  assign o_busy             = en_q && (state_q != ST_IDLE);
  assign o_done             = done;

endmodule

// File: tb/tb_gng_noise_ctrl.sv
// Scoreboard bench for gng_noise_ctrl with a 3-cycle gng_top model.
module tb_gng_noise_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_stop, i_sigma_load, i_noise_ready;
  logic [15:0] i_burst_len, i_sigma;
  logic        o_gng_ce, o_noise_valid, o_busy, o_done;
  logic [15:0] o_sigma_multiplier;
  logic [31:0] i_gng_data, o_noise_data;
  logic        i_gng_valid;

  logic [2:0]  pipe_q;
  logic [31:0] seq_q;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, beats = 0, last_beat = 0;
  int done_cnt = 0, done_cyc = 0;
  int gv_cnt = 0, warm_seen = 0, qmax = 0;
  bit ce_seen = 0;
  int rdy_mode = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  gng_noise_ctrl dut (
    .i_clock            (clk),
    .i_reset            (rst_n),
    .i_start            (i_start),
    .i_stop             (i_stop),
    .i_burst_len        (i_burst_len),
    .i_sigma            (i_sigma),
    .i_sigma_load       (i_sigma_load),
    .o_gng_ce           (o_gng_ce),
    .o_sigma_multiplier (o_sigma_multiplier),
    .i_gng_data         (i_gng_data),
    .i_gng_valid        (i_gng_valid),
    .o_noise_data       (o_noise_data),
    .o_noise_valid      (o_noise_valid),
    .i_noise_ready      (i_noise_ready),
    .o_busy             (o_busy),
    .o_done             (o_done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
      seq_q  <= '0;
    end else begin
      pipe_q <= {pipe_q[1:0], o_gng_ce};
      if (pipe_q[2]) seq_q <= seq_q + 1;
    end
  end

  assign i_gng_valid = pipe_q[2];
  assign i_gng_data  = seq_q * 32'h9E3779B9 + 32'h1234;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      warm_seen = 0;
      gv_cnt = 0;
    end else begin
      if (sb.size() > qmax) qmax = sb.size();
      if (o_gng_ce) ce_seen = 1;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_noise_valid && i_noise_ready) begin
        beats++;
        last_beat = cyc;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("data", o_noise_data, sb.pop_front());
      end
      if (i_gng_valid) begin
        gv_cnt++;
        if (warm_seen < 32) warm_seen++;
        else sb.push_back(i_gng_data);
      end
    end
  end

  initial begin
    int rc = 0;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      i_noise_ready = (rdy_mode == 0) ? 1'b1 : ((rc % 3) == 0);
    end
  end

  task automatic start_burst(input int len);
    @(posedge clk); #1;
    i_burst_len = 16'(len);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int i;
    repeat (3) @(negedge clk);
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (!o_busy) break;
    end
    if (i == max) chk(tag, 0, 1);
  endtask

  task automatic wait_done(input string tag, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_done) break;
    end
    if (i == max) chk(tag, 0, 1);
  endtask

  task automatic burst(input string tag, input int len);
    int b0, d0;
    b0 = beats;
    d0 = done_cnt;
    start_burst(len);
    wait_done({tag, "_tmo"}, 2000);
    repeat (5) @(negedge clk);
    chk({tag, "_beats"}, beats - b0, len);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_order"}, done_cyc > last_beat, 1);
    chk({tag, "_sb"}, sb.size(), 0);
  endtask

  initial begin
    int b0, d0;
    rst_n = 1'b0;
    i_start = 0; i_stop = 0; i_sigma_load = 0;
    i_burst_len = 0; i_sigma = 0; i_noise_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_ce", o_gng_ce, 0);
    chk("rst_nv", o_noise_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sigma", o_sigma_multiplier, 2048);
    @(posedge clk); #1 rst_n = 1'b1;

    wait_idle("warm_tmo", 300);
    chk("warm_valids", gv_cnt, 32);
    chk("warm_nv", beats, 0);
    chk("warm_ce", ce_seen, 1);
    chk("idle_ce", o_gng_ce, 0);

    burst("b10", 10);

    rdy_mode = 1;
    burst("b20", 20);
    rdy_mode = 0;
    chk("fifo_max", qmax <= 4, 1);

    start_burst(30);
    repeat (5) @(posedge clk);
    #1 i_sigma = 16'd4096; i_sigma_load = 1'b1;
    @(posedge clk); #1 i_sigma_load = 1'b0;
    @(negedge clk);
    chk("sig_run", o_sigma_multiplier, 2048);
    wait_done("sig_tmo", 2000);
    chk("sig_drain", o_sigma_multiplier, 2048);
    repeat (3) @(negedge clk);
    chk("sig_idle", o_sigma_multiplier, 4096);
    chk("sig_sb", sb.size(), 0);

    b0 = beats;
    d0 = done_cnt;
    start_burst(0);
    repeat (50) @(posedge clk);
    #1 i_stop = 1'b1;
    @(posedge clk); #1 i_stop = 1'b0;
    @(negedge clk);
    chk("cont_ce_off", o_gng_ce, 0);
    chk("cont_busy", o_busy, 1);
    wait_done("cont_tmo", 500);
    repeat (3) @(negedge clk);
    chk("cont_beats", beats - b0 > 20, 1);
    chk("cont_done", done_cnt - d0, 1);
    chk("cont_sb", sb.size(), 0);

    d0 = done_cnt;
    start_burst(0);
    repeat (20) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_ce", o_gng_ce, 0);
    chk("mid_nv", o_noise_valid, 0);
    chk("mid_busy", o_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b0 = beats;
    wait_idle("rewarm_tmo", 300);
    chk("rewarm_valids", gv_cnt, 32);
    chk("rewarm_nv", beats - b0, 0);
    chk("rewarm_nodone", done_cnt - d0, 0);
    burst("b5", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
